// File: rtl/imem_loader.sv
// Streams a program into instruction memory, pads unused words with HALT_WORD,
// then releases the CPU. Define IMEM_LOADER_CHECKSUM_EN to treat the last word as a checksum.
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [15:0]       in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [15:0]       imem_wdata_o,
    output logic              cpu_run_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   word_count_o
);

    typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, ERR} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                run_q, run_d;
    logic                err_q, err_d;
    logic                fire, at_last;
    logic [ADDR_W:0]     cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]         sum_q, sum_d;
`endif

    assign in_ready_o = (state_q == LOAD);
    assign fire       = in_valid_i && in_ready_o;
    assign at_last    = (addr_q == LAST_ADDR);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // start restarts from any state except an in-progress load
        if (start_i && state_q != LOAD) begin
            state_d = LOAD;
            addr_d  = '0;
            cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                LOAD: if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (in_last_i) begin
                        // Overflow traps at the top address, so a matching checksum always leaves room to pad
                        state_d = (in_data_i == sum_q) ? FILL : ERR;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = in_data_i;
                        cnt_d   = cnt_inc;
                        sum_d   = sum_q + in_data_i;
                        if (at_last) state_d = ERR;
                        else         addr_d  = addr_q + ADDR_W'(1);
                    end
`else
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data_i;
                    cnt_d   = cnt_inc;
                    if (at_last) begin
                        state_d = in_last_i ? RUN : ERR;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (in_last_i) state_d = FILL;
                    end
`endif
                end
                FILL: begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = HALT_WORD;
                    if (at_last) state_d = RUN;
                    else         addr_d  = addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // cpu_run trails entry into RUN by one cycle but drops on the start edge
    assign run_d = (state_q == RUN) && !start_i;
    assign err_d = (state_d == ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign cpu_run_o    = run_q;
    assign load_err_o   = err_q;
    assign word_count_o = cnt_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, number of 16-bit instruction words in fetch memory.
REQ-002 Parameter: ADDR_W, 8, address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 Parameter: HALT_WORD, 16'hFFFF, word written to every unloaded address.
REQ-004 CLK  in  1  single system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a new program load.
REQ-007 in_valid  in  1  upstream word valid.
REQ-008 in_data  in  16  upstream program word.
REQ-009 in_last  in  1  marks final word of the program; qualified by in_valid.
REQ-010 in_ready  out  1  loader accepts a word this cycle.
REQ-011 imem_we  out  1  fetch-memory write strobe.
REQ-012 imem_addr  out  ADDR_W  fetch-memory write address.
REQ-013 imem_wdata  out  16  fetch-memory write data.
REQ-014 cpu_run  out  1  1 = CPU released from hold; 0 = CPU held in reset.
REQ-015 load_err  out  1  sticky error flag for the last load attempt.
REQ-016 word_count  out  ADDR_W+1  number of program words stored by the last load.

Function
REQ-017 States: IDLE, LOAD, FILL, RUN, ERR; exactly one active.
REQ-018 Transfer occurs on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in LOAD.
REQ-019 IDLE: outputs inactive; start -> LOAD, address counter and word_count cleared, load_err cleared.
REQ-020 LOAD: each transfer SHALL drive imem_we=1, imem_addr=current address, imem_wdata=in_data on the following cycle (1-cycle registered latency), then increment address.
REQ-021 LOAD, transfer with in_last=1 and stored address < DEPTH-1 -> FILL; with stored address = DEPTH-1 -> RUN.
REQ-022 LOAD, transfer at address DEPTH-1 with in_last=0 -> word stored, then ERR (overflow); address SHALL not wrap.
REQ-023 FILL: one write of HALT_WORD per cycle to each remaining address up to DEPTH-1, in_ready=0; after the DEPTH-1 write -> RUN.
REQ-024 RUN: cpu_run=1 registered, asserted the cycle after entering RUN; no writes issued.
REQ-025 start in RUN, FILL or ERR -> LOAD next cycle; cpu_run SHALL fall the same edge; start in LOAD is ignored.
REQ-026 ERR: load_err=1, cpu_run=0, no writes; leave only via start or reset.
REQ-027 word_count SHALL count stored program words (excluding FILL writes), saturating at DEPTH.
REQ-028 in_valid with in_ready=0 SHALL be held off without data loss; upstream must hold in_data stable.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, load_err=0, word_count=0, checksum accumulator=0.
REQ-030 Reset mid-LOAD or mid-FILL SHALL abort the load; partially written memory is not restored; cpu_run stays 0 until a complete load.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: the in_last word is a checksum, not stored; loader sums stored words modulo 2**16; match -> FILL/RUN per REQ-021 using last stored address; mismatch -> ERR.
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN undefined: the in_last word is an ordinary program word stored per REQ-020; no checksum logic is present.

Verification
REQ-033 Load 3 words 16'h0000,16'h5101,16'hFFFF (last on third), no macro -> writes addr 0..2, FILL 3..255 with FFFF, word_count=3, cpu_run=1 one cycle after addr 255 write.
REQ-034 in_valid toggling 1/0 each cycle over 4 words -> exactly 4 writes at addr 0..3, data in order, no duplicates.
REQ-035 256 words without in_last -> 256 writes, load_err=1, cpu_run=0; then start + 1 word with last -> load_err=0, RUN.
REQ-036 Macro on: words 16'h0001,16'h0002 then last 16'h0003 -> 2 stored, RUN; repeat with last 16'h0004 -> ERR, cpu_run=0.
REQ-037 rst=0 asserted during FILL at addr 100 -> all outputs zero immediately, IDLE; start and reload complete normally.
REQ-038 start while in RUN -> cpu_run=0 next edge, LOAD, in_ready=1, new words written from addr 0.
